// File: rtl/mv_select_if.sv
// Candidate-SAD input and motion-vector result bundle for mv_select.
// master drives start and the SAD stream; slave is the selector itself.
interface mv_select_if #(
   parameter int SW_W  = 8,
   parameter int SW_H  = 8,
   parameter int SAD_W = 14
);
   localparam int XW = $clog2(SW_W);
   localparam int YW = $clog2(SW_H);

   logic             start;
   logic             sad_valid;
   logic [SAD_W-1:0] sad_data;
   logic             busy;
   logic             mv_valid;
   logic [XW-1:0]    mv_x;
   logic [YW-1:0]    mv_y;
   logic [SAD_W-1:0] min_sad;

   modport master (
      output start, sad_valid, sad_data,
      input  busy, mv_valid, mv_x, mv_y, min_sad
   );

   modport slave (
      input  start, sad_valid, sad_data,
      output busy, mv_valid, mv_x, mv_y, min_sad
   );
endinterface

// File: rtl/mv_select.sv
// Minimum-SAD motion vector selector over a raster-ordered SW_W x SW_H search window.
// Optional MV_ZERO_BIAS_EN: the centre (zero-motion) candidate gets a ZERO_BIAS SAD credit.
//
// state  | meaning
// IDLE   | waiting for start, SAD stream ignored
// SEARCH | consuming candidates, tracking the running minimum
// DONE   | one-cycle result strobe; start here chains the next search
module mv_select #(
   parameter int SW_W      = 8,
   parameter int SW_H      = 8,
   parameter int SAD_W     = 14,
   parameter int ZERO_BIAS = 16
) (
   input logic        clk,
   input logic        rst,
   mv_select_if.slave bus
);

   localparam int XW = $clog2(SW_W);
   localparam int YW = $clog2(SW_H);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SEARCH = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   localparam logic [XW-1:0]    HALF_X = XW'(SW_W / 2);
   localparam logic [YW-1:0]    HALF_Y = YW'(SW_H / 2);
   localparam logic [XW-1:0]    LAST_X = XW'(SW_W - 1);
   localparam logic [YW-1:0]    LAST_Y = YW'(SW_H - 1);
   localparam logic [SAD_W-1:0] BIAS   = SAD_W'(ZERO_BIAS);

`ifdef MV_ZERO_BIAS_EN
   localparam bit BIAS_EN = 1'b1;
`else
   localparam bit BIAS_EN = 1'b0;
`endif

   logic [1:0]       state;
   logic [XW-1:0]    x_cnt;
   logic [YW-1:0]    y_cnt;
   logic [XW-1:0]    best_x;
   logic [YW-1:0]    best_y;
   logic [SAD_W-1:0] run_min;
   logic [SAD_W-1:0] best_sad;
   logic [XW-1:0]    mv_x_q;
   logic [YW-1:0]    mv_y_q;
   logic [SAD_W-1:0] min_sad_q;

   logic             accept;
   logic             launch;
   logic             is_zero_cand;
   logic             take;
   logic [SAD_W-1:0] cmp_val;
   logic [XW-1:0]    win_x;
   logic [YW-1:0]    win_y;
   logic [SAD_W-1:0] win_sad;

   always_comb begin
      accept       = (state == S_SEARCH) && bus.sad_valid;
      launch       = bus.start && ((state == S_IDLE) || (state == S_DONE));
      is_zero_cand = (x_cnt == HALF_X) && (y_cnt == HALF_Y);
      cmp_val      = bus.sad_data;
      // The credit only shapes the comparison; min_sad always reports the raw SAD.
      if (BIAS_EN && is_zero_cand) begin
         cmp_val = (bus.sad_data > BIAS) ? (bus.sad_data - BIAS) : '0;
      end
      take    = cmp_val < run_min;
      win_x   = take ? x_cnt : best_x;
      win_y   = take ? y_cnt : best_y;
      win_sad = take ? bus.sad_data : best_sad;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         x_cnt     <= '0;
         y_cnt     <= '0;
         best_x    <= '0;
         best_y    <= '0;
         run_min   <= '1;
         best_sad  <= '1;
         mv_x_q    <= '0;
         mv_y_q    <= '0;
         min_sad_q <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (launch) begin
                  state    <= S_SEARCH;
                  x_cnt    <= '0;
                  y_cnt    <= '0;
                  best_x   <= '0;
                  best_y   <= '0;
                  run_min  <= '1;
                  best_sad <= '1;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_SEARCH: begin
               if (accept) begin
                  if (take) begin
                     run_min  <= cmp_val;
                     best_sad <= bus.sad_data;
                     best_x   <= x_cnt;
                     best_y   <= y_cnt;
                  end
                  if (x_cnt == LAST_X) begin
                     x_cnt <= '0;
                     if (y_cnt == LAST_Y) begin
                        // Result includes the final candidate, so register from the win_* view.
                        state     <= S_DONE;
                        y_cnt     <= '0;
                        mv_x_q    <= win_x - HALF_X;
                        mv_y_q    <= win_y - HALF_Y;
                        min_sad_q <= win_sad;
                     end else begin
                        y_cnt <= y_cnt + YW'(1);
                     end
                  end else begin
                     x_cnt <= x_cnt + XW'(1);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy     = (state == S_SEARCH);
   assign bus.mv_valid = (state == S_DONE);
   assign bus.mv_x     = mv_x_q;
   assign bus.mv_y     = mv_y_q;
   assign bus.min_sad  = min_sad_q;

endmodule

// File: tb/tb_mv_select.sv
// Directed bench for mv_select: hand-computed winners for an 8x8 window of 14-bit SADs.
module tb_mv_select;

   logic clk;
   logic rst;

   mv_select_if #(.SW_W(8), .SW_H(8), .SAD_W(14)) bus ();

   mv_select #(.SW_W(8), .SW_H(8), .SAD_W(14), .ZERO_BIAS(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [13:0] sads [64];
   int tests = 0;
   int fails = 0;
   int pulses = 0;
   int exp_pulses = 0;

   always @(negedge clk) if (bus.mv_valid === 1'b1) pulses++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] s3(input int v);
      logic [31:0] t;
      t = v;
      return {29'b0, t[2:0]};
   endfunction

   task automatic fill(input logic [13:0] base);
      for (int i = 0; i < 64; i++) sads[i] = base;
   endtask

   task automatic do_start(input bit sad_too);
      bus.start     = 1'b1;
      bus.sad_valid = sad_too;
      bus.sad_data  = 14'd0;
      @(negedge clk);
      bus.start     = 1'b0;
      bus.sad_valid = 1'b0;
   endtask

   task automatic feed(input int n, input bit gaps, input bit mid_start);
      for (int i = 0; i < n; i++) begin
         if (gaps && ($urandom_range(0, 1) == 1)) begin
            bus.sad_valid = 1'b0;
            @(negedge clk);
         end
         bus.sad_valid = 1'b1;
         bus.sad_data  = sads[i];
         bus.start     = mid_start && (i == 20);
         @(negedge clk);
      end
      bus.sad_valid = 1'b0;
      bus.start     = 1'b0;
   endtask

   task automatic check_result(input string tag, input int ex, input int ey, input logic [13:0] es);
      exp_pulses++;
      check({tag, "_valid"}, 32'(bus.mv_valid), 32'd1);
      check({tag, "_busy"},  32'(bus.busy), 32'd0);
      check({tag, "_mv_x"},  32'(bus.mv_x), s3(ex));
      check({tag, "_mv_y"},  32'(bus.mv_y), s3(ey));
      check({tag, "_sad"},   32'(bus.min_sad), 32'(es));
   endtask

   initial begin
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.sad_valid = 1'b0;
      bus.sad_data  = 14'd0;
      repeat (2) @(negedge clk);
      check("rst_busy",  32'(bus.busy), 32'd0);
      check("rst_valid", 32'(bus.mv_valid), 32'd0);
      check("rst_mv_x",  32'(bus.mv_x), 32'd0);
      check("rst_mv_y",  32'(bus.mv_y), 32'd0);
      check("rst_sad",   32'(bus.min_sad), 32'd0);
      rst = 1'b0;

      // stray SADs while idle must not start anything
      bus.sad_valid = 1'b1;
      bus.sad_data  = 14'd1;
      repeat (3) @(negedge clk);
      bus.sad_valid = 1'b0;
      check("idle_busy", 32'(bus.busy), 32'd0);

      // single minimum at (2,5); extra start mid-search
      fill(14'd1000);
      sads[42] = 14'd37;
      do_start(1'b1);
      check("search_busy", 32'(bus.busy), 32'd1);
      feed(64, 1'b0, 1'b1);
      check_result("single", -2, 1, 14'd37);
      @(negedge clk);
      check("done_to_idle_busy", 32'(bus.busy), 32'd0);
      check("done_one_cycle", 32'(bus.mv_valid), 32'd0);
      check("hold_mv_x", 32'(bus.mv_x), s3(-2));

      // tie at (1,1) and (6,6): first wins; random gaps
      fill(14'd1000);
      sads[9]  = 14'd50;
      sads[54] = 14'd50;
      do_start(1'b0);
      feed(64, 1'b1, 1'b0);
      check_result("tie", -3, -3, 14'd50);
      @(negedge clk);

      // zero-motion bias case
      fill(14'd500);
      sads[36] = 14'd100;
      sads[0]  = 14'd90;
      do_start(1'b0);
      feed(64, 1'b0, 1'b0);
`ifdef MV_ZERO_BIAS_EN
      check_result("bias", 0, 0, 14'd100);
`else
      check_result("bias", -4, -4, 14'd90);
`endif
      @(negedge clk);

      // reset mid-search, then a fresh full search
      fill(14'd1000);
      do_start(1'b0);
      feed(30, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check("midrst_busy",  32'(bus.busy), 32'd0);
      check("midrst_valid", 32'(bus.mv_valid), 32'd0);
      check("midrst_mv_x",  32'(bus.mv_x), 32'd0);
      check("midrst_mv_y",  32'(bus.mv_y), 32'd0);
      check("midrst_sad",   32'(bus.min_sad), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.sad_valid = 1'b1;
      bus.sad_data  = 14'd2;
      repeat (4) @(negedge clk);
      bus.sad_valid = 1'b0;
      check("postrst_idle", 32'(bus.busy), 32'd0);
      fill(14'd1000);
      sads[63] = 14'd5;
      do_start(1'b0);
      feed(64, 1'b0, 1'b0);
      check_result("after_rst", 3, 3, 14'd5);
      @(negedge clk);

      // back-to-back: start during DONE, second search with random gaps
      fill(14'd1000);
      sads[20] = 14'd3;
      do_start(1'b0);
      feed(64, 1'b0, 1'b0);
      check_result("b2b_first", 0, -2, 14'd3);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b_busy",  32'(bus.busy), 32'd1);
      check("b2b_valid", 32'(bus.mv_valid), 32'd0);
      fill(14'd800);
      sads[21] = 14'd7;
      sads[60] = 14'd7;
      feed(64, 1'b1, 1'b0);
      check_result("b2b_second", 1, -2, 14'd7);
      @(negedge clk);

      // every SAD all-ones
      fill(14'h3FFF);
      do_start(1'b0);
      feed(64, 1'b0, 1'b0);
`ifdef MV_ZERO_BIAS_EN
      check_result("all_ones", 0, 0, 14'h3FFF);
`else
      check_result("all_ones", -4, -4, 14'h3FFF);
`endif
      repeat (3) @(negedge clk);
      check("pulse_count", 32'(pulses), 32'(exp_pulses));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
